// File: rtl/cla_multiword_seq_pkg.sv
// Shared types and default sizing for the multi-word sequential CLA adder.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_W = 16;
  localparam int DEF_N = 4;

endpackage

// File: rtl/cla_multiword_seq_slice.sv
// Combinational W-bit adder built from 4-bit carry-lookahead groups with
// a second lookahead level across the group generate/propagate terms.
module cla_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  localparam int NG = W / 4;

  logic [W-1:0]  g_s;
  logic [W-1:0]  p_s;
  logic [W-1:0]  c_s;
  logic [NG-1:0] gg_s;
  logic [NG-1:0] gp_s;
  logic [NG:0]   gc_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // group generate/propagate, group carries, then per-bit carries inside each group
  always_comb begin
    logic cv;
    gg_s = {NG{1'b0}};
    gp_s = {NG{1'b0}};
    gc_s = {(NG+1){1'b0}};
    c_s  = {W{1'b0}};
    cv   = 1'b0;
    for (int k = 0; k < NG; k++) begin
      gp_s[k] = &p_s[4*k +: 4];
      gg_s[k] = g_s[4*k+3]
              | (p_s[4*k+3] & g_s[4*k+2])
              | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
              | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
    end
    gc_s[0] = cin;
    // each group carry is the flattened sum-of-products over all lower groups
    for (int k = 1; k <= NG; k++) begin
      cv = cin;
      for (int j = 0; j < k; j++) begin
        cv = gg_s[j] | (gp_s[j] & cv);
      end
      gc_s[k] = cv;
    end
    for (int k = 0; k < NG; k++) begin
      c_s[4*k]   = gc_s[k];
      c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & gc_s[k]);
      c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+1] & p_s[4*k] & gc_s[k]);
      c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & gc_s[k]);
    end
  end

  assign s    = p_s ^ c_s;
  assign cout = gc_s[NG];

endmodule

// File: rtl/cla_multiword_seq.sv
// N*W-bit add/subtract performed one W-bit slice per cycle through a single
// shared CLA slice, with valid/ready handshakes on operand and result sides.
module cla_multiword_seq
  import cla_seq_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  input  logic           cin,
  input  logic           sub,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] sum,
  output logic           cout,
  output logic           ovf,
  output logic           busy
);

  localparam int NW = N * W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_e          state_r;
  logic [IW-1:0]   idx_r;
  logic            carry_r;
  logic [NW-1:0]   a_r;
  logic [NW-1:0]   b_r;
  logic [NW-1:0]   sum_r;
  logic            cout_r;
  logic            ovf_r;
  logic            out_valid_r;
  logic            in_ready_r;
  logic            busy_r;
  logic [W-1:0]    slice_a_s;
  logic [W-1:0]    slice_b_s;
  logic [W-1:0]    slice_sum_s;
  logic            slice_cout_s;

  assign slice_a_s = a_r[int'(idx_r)*W +: W];
  assign slice_b_s = b_r[int'(idx_r)*W +: W];

  cla_slice #(.W(W)) u_slice (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .cin  (carry_r),
    .s    (slice_sum_s),
    .cout (slice_cout_s)
  );

  // control FSM, slice index, carry chain and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= {IW{1'b0}};
      carry_r     <= 1'b0;
      a_r         <= {NW{1'b0}};
      b_r         <= {NW{1'b0}};
      sum_r       <= {NW{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b ^ {NW{sub}};
            carry_r    <= sub ? 1'b1 : cin;
            idx_r      <= {IW{1'b0}};
            sum_r      <= {NW{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= RUN;
          end
        end
        RUN: begin
          sum_r[int'(idx_r)*W +: W] <= slice_sum_s;
          carry_r                   <= slice_cout_s;
          if (idx_r == LAST) begin
            cout_r      <= slice_cout_s;
            // overflow: operands agree in sign but the top result bit does not
            ovf_r       <= (a_r[NW-1] == b_r[NW-1]) && (slice_sum_s[W-1] != a_r[NW-1]);
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Self-checking bench for cla_multiword_seq (W=16, N=4): directed vector table,
// handshake corner sequences and a randomized run against a full-width model.
module tb_cla_multiword_seq;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int NW = W * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] a;
  logic [NW-1:0] b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] sum;
  logic          cout;
  logic          ovf;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cla_multiword_seq #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  typedef struct {
    logic [NW-1:0] a;
    logic [NW-1:0] b;
    logic          cin;
    logic          sub;
    logic [NW-1:0] es;
    logic          ec;
    logic          eo;
  } vec_t;

  typedef struct {
    logic [NW-1:0] s;
    logic          c;
    logic          o;
  } res_t;

  vec_t vt[7];
  res_t exp_q[$];

  task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: plain full-width arithmetic; overflow from a sign-extended exact result.
  function automatic res_t model(input logic [NW-1:0] ma, input logic [NW-1:0] mb,
                                 input logic mc, input logic ms);
    res_t r;
    logic [NW:0]          full;
    logic signed [NW+1:0] ext;
    if (ms) begin
      r.s = ma - mb;
      r.c = (ma >= mb);
      ext = $signed({ma[NW-1], ma[NW-1], ma}) - $signed({mb[NW-1], mb[NW-1], mb});
    end else begin
      full = {1'b0, ma} + {1'b0, mb} + {{NW{1'b0}}, mc};
      r.s  = full[NW-1:0];
      r.c  = full[NW];
      ext  = $signed({ma[NW-1], ma[NW-1], ma}) + $signed({mb[NW-1], mb[NW-1], mb})
           + $signed({{(NW+1){1'b0}}, mc});
    end
    r.o = ext[NW] ^ ext[NW-1];
    return r;
  endfunction

  function automatic logic [NW-1:0] rnd_op();
    logic [NW-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = {NW{1'b1}};
      1:       v = {1'b1, {(NW-1){1'b0}}};
      2:       v = {{(NW/2){1'b0}}, {(NW/2){1'b1}}};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic start(input logic [NW-1:0] ta, input logic [NW-1:0] tb2,
                       input logic tc, input logic ts);
    a = ta; b = tb2; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = ~tc; sub = ~ts;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".out_valid_clr"}, NW'(out_valid), NW'(0));
    chk({tag, ".in_ready_set"},  NW'(in_ready),  NW'(1));
    chk({tag, ".busy_clr"},      NW'(busy),      NW'(0));
  endtask

  task automatic do_op(input vec_t v, input string tag);
    int lat;
    chk({tag, ".in_ready"}, NW'(in_ready), NW'(1));
    start(v.a, v.b, v.cin, v.sub);
    chk({tag, ".busy_run"}, NW'(busy), NW'(1));
    wait_valid(lat);
    chk({tag, ".latency"},  NW'(lat),      NW'(N));
    chk({tag, ".sum"},      sum,           v.es);
    chk({tag, ".cout"},     NW'(cout),     NW'(v.ec));
    chk({tag, ".ovf"},      NW'(ovf),      NW'(v.eo));
    chk({tag, ".in_ready_done"}, NW'(in_ready), NW'(0));
    retire(tag);
  endtask

  initial begin
    int   lat;
    int   accepted;
    int   retired;
    int   cyc;
    vec_t v;
    res_t r;
    res_t e;
    logic iv, s_ir, s_ov;
    logic [NW-1:0] ra, rb, s_sum;
    logic rc, rs, s_cout, s_ovf;

    vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
    vt[1] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vt[2] = '{64'h0000_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0};
    vt[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vt[4] = '{64'h3, 64'h5, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vt[5] = '{64'hA, 64'hA, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0};
    vt[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = {NW{1'b0}}; b = {NW{1'b0}}; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", NW'(out_valid), NW'(0));
    chk("reset.in_ready",  NW'(in_ready),  NW'(1));
    chk("reset.busy",      NW'(busy),      NW'(0));
    chk("reset.sum",       sum,            NW'(0));
    chk("reset.cout",      NW'(cout),      NW'(0));
    chk("reset.ovf",       NW'(ovf),       NW'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) do_op(vt[i], $sformatf("vec%0d", i));

    // result held through a long stall; requests in DONE are dropped
    v.a = 64'h1234_5678_9ABC_DEF0; v.b = 64'h1111_1111_1111_1111; v.cin = 1'b0; v.sub = 1'b0;
    e = model(v.a, v.b, v.cin, v.sub);
    start(v.a, v.b, v.cin, v.sub);
    wait_valid(lat);
    chk("stall.latency", NW'(lat), NW'(N));
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("stall%0d.out_valid", i), NW'(out_valid), NW'(1));
      chk($sformatf("stall%0d.sum", i),       sum,            e.s);
      chk($sformatf("stall%0d.cout", i),      NW'(cout),      NW'(e.c));
      chk($sformatf("stall%0d.ovf", i),       NW'(ovf),       NW'(e.o));
      chk($sformatf("stall%0d.in_ready", i),  NW'(in_ready),  NW'(0));
    end
    in_valid = 1'b0;
    retire("stall");
    @(posedge clk); #1;
    chk("stall.not_queued", NW'(busy), NW'(0));

    // retire and new request in the same cycle: accept lands one cycle later
    start(64'h22, 64'h11, 1'b0, 1'b0);
    wait_valid(lat);
    a = 64'h5; b = 64'h3; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("overlap.out_valid_clr", NW'(out_valid), NW'(0));
    chk("overlap.idle_ready",    NW'(in_ready),  NW'(1));
    chk("overlap.idle_busy",     NW'(busy),      NW'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("overlap.accepted", NW'(busy), NW'(1));
    wait_valid(lat);
    chk("overlap.latency", NW'(lat), NW'(N));
    chk("overlap.sum",     sum,      NW'(8));
    retire("overlap");

    // asynchronous reset in the middle of RUN
    start(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrun.partial_sum", NW'(sum != {NW{1'b0}}), NW'(1));
    rst = 1'b1;
    #1;
    chk("midrun_rst.sum",       sum,            NW'(0));
    chk("midrun_rst.cout",      NW'(cout),      NW'(0));
    chk("midrun_rst.ovf",       NW'(ovf),       NW'(0));
    chk("midrun_rst.out_valid", NW'(out_valid), NW'(0));
    chk("midrun_rst.in_ready",  NW'(in_ready),  NW'(1));
    chk("midrun_rst.busy",      NW'(busy),      NW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    v.a = 64'h5; v.b = 64'h3; v.cin = 1'b0; v.sub = 1'b0;
    v.es = 64'h8; v.ec = 1'b0; v.eo = 1'b0;
    do_op(v, "post_rst");

    // randomized back-to-back traffic with consumer stalls
    accepted = 0; retired = 0; cyc = 0;
    while (retired < 1000 && cyc < 40000) begin
      iv = (accepted < 1000) && ($urandom_range(0, 7) != 0);
      ra = rnd_op(); rb = rnd_op();
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      in_valid = iv; a = ra; b = rb; cin = rc; sub = rs;
      out_ready = ($urandom_range(0, 3) != 0);
      s_ir = in_ready; s_ov = out_valid; s_sum = sum; s_cout = cout; s_ovf = ovf;
      @(posedge clk); #1;
      cyc++;
      if (iv && s_ir) begin
        exp_q.push_back(model(ra, rb, rc, rs));
        accepted++;
      end
      if (s_ov && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand.unexpected_result", NW'(1), NW'(0));
        end else begin
          r = exp_q.pop_front();
          chk($sformatf("rand%0d.result", retired),
              {s_sum[NW-1:2], 1'b0, 1'b0} ^ {{(NW-2){1'b0}}, s_cout, s_ovf} ^ {NW{1'b0}} | NW'(0),
              {r.s[NW-1:2], 1'b0, 1'b0} ^ {{(NW-2){1'b0}}, r.c, r.o});
          chk($sformatf("rand%0d.sum_lo", retired), NW'(s_sum[1:0]), NW'(r.s[1:0]));
        end
        retired++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rand.retired_count", NW'(retired),      NW'(1000));
    chk("rand.queue_empty",   NW'(exp_q.size()), NW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
